// File: rtl/mig_pkg.sv
// Shared types for the majority-inverter-graph sequencer: instruction word, FSM states, widths.
package mig_pkg;

    localparam int unsigned MIG_WIDTH      = 8;
    localparam int unsigned MIG_NREGS      = 16;
    localparam int unsigned MIG_PROG_DEPTH = 32;

    function automatic int unsigned addr_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned AW = addr_width(MIG_NREGS);
    localparam int unsigned IW = 4 * AW + 4;

    typedef logic [AW-1:0] raddr_t;

    typedef struct packed {
        raddr_t dst;
        raddr_t src1;
        logic   inv1;
        raddr_t src2;
        logic   inv2;
        raddr_t src3;
        logic   inv3;
        logic   last;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam raddr_t REG_ZERO = '0;

endpackage

// File: rtl/mig_maj3.sv
// Bitwise three-input majority gate bank.
module mig_maj3 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/mig_regfile.sv
// Register file: three execution read ports, one host read port, one write port; r0 reads zero.
module mig_regfile
    import mig_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREGS = 16,
    localparam int unsigned RW   = addr_width(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [RW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [RW-1:0]    raddr1,
    input  logic [RW-1:0]    raddr2,
    input  logic [RW-1:0]    raddr3,
    input  logic [RW-1:0]    hraddr,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2,
    output logic [WIDTH-1:0] rdata3,
    output logic [WIDTH-1:0] hrdata
);

    logic [WIDTH-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != RW'(0))) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == RW'(0)) ? '0 : mem[raddr1];
    assign rdata2 = (raddr2 == RW'(0)) ? '0 : mem[raddr2];
    assign rdata3 = (raddr3 == RW'(0)) ? '0 : mem[raddr3];
    assign hrdata = (hraddr == RW'(0)) ? '0 : mem[hraddr];

endmodule

// File: rtl/mig_sequencer.sv
// Runs a stored Maj3/inverter program over the register file, one instruction per cycle.
module mig_sequencer
    import mig_pkg::*;
#(
    parameter int unsigned WIDTH      = MIG_WIDTH,
    parameter int unsigned NREGS      = MIG_NREGS,
    parameter int unsigned PROG_DEPTH = MIG_PROG_DEPTH,
    localparam int unsigned PW        = addr_width(PROG_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prog_we,
    input  logic [PW-1:0]    prog_addr,
    input  logic [IW-1:0]    prog_data,
    input  logic             reg_we,
    input  logic [AW-1:0]    reg_waddr,
    input  logic [WIDTH-1:0] reg_wdata,
    input  logic [AW-1:0]    reg_raddr,
    output logic [WIDTH-1:0] reg_rdata,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [PW-1:0] LAST_PC = PW'(PROG_DEPTH - 1);

    logic [IW-1:0]    prog_mem [PROG_DEPTH];
    state_t           state, state_next;
    logic [PW-1:0]    pc, pc_next;
    instr_t           ins;
    logic             exec_we;
    logic             host_ok;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic [WIDTH-1:0] rd1, rd2, rd3;
    logic [WIDTH-1:0] op1, op2, op3;
    logic [WIDTH-1:0] res;

    assign ins     = instr_t'(prog_mem[pc]);
    assign host_ok = (state != RUN);

    // Program memory is deliberately not reset.
    always_ff @(posedge clk) begin
        if (prog_we && host_ok) begin
            prog_mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        exec_we    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    pc_next    = '0;
                end
            end
            RUN: begin
                exec_we = (ins.dst != REG_ZERO);
                if (ins.last || (pc == LAST_PC)) begin
                    state_next = DONE;
                end else begin
                    pc_next = pc + PW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // err flags a host write dropped on the previous edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
            err   <= (state == RUN) && (prog_we || reg_we);
        end
    end

    assign rf_we    = host_ok ? reg_we    : exec_we;
    assign rf_waddr = host_ok ? reg_waddr : ins.dst;
    assign rf_wdata = host_ok ? reg_wdata : res;

    mig_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata),
        .raddr1 (ins.src1),
        .raddr2 (ins.src2),
        .raddr3 (ins.src3),
        .hraddr (reg_raddr),
        .rdata1 (rd1),
        .rdata2 (rd2),
        .rdata3 (rd3),
        .hrdata (reg_rdata)
    );

    assign op1 = ins.inv1 ? ~rd1 : rd1;
    assign op2 = ins.inv2 ? ~rd2 : rd2;
    assign op3 = ins.inv3 ? ~rd3 : rd3;

    mig_maj3 #(
        .WIDTH (WIDTH)
    ) u_maj3 (
        .a (op1),
        .b (op2),
        .c (op3),
        .y (res)
    );

endmodule
